// File: rtl/dh_exchange_ctrl.sv
// dh_exchange_ctrl
//   Sequences a two-party Diffie-Hellman exchange through one shared
//   modular-exponentiation engine: pub A = g^a, pub B = g^b, key A = B^a,
//   key B = A^b (all mod p), then compares both keys and strobes done_o.
//   A per-operation watchdog aborts the exchange if the engine stalls.
//
// Ports
//   clk, rst             clock; synchronous active-low reset
//   start_i              begin exchange (sampled only in IDLE)
//   g_i, p_i             generator, prime modulus (latched on start)
//   a_priv_i, b_priv_i   private exponents (latched on start)
//   me_start_o           one-cycle engine start pulse
//   me_base/exp/mod_o    engine operands, stable through the wait phase
//   me_done_i            engine result-valid pulse
//   me_result_i          engine result
//   pub_a_o, pub_b_o     registered public values
//   key_a_o, key_b_o     registered shared keys
//   busy_o               high outside IDLE
//   done_o               one-cycle completion (or abort) strobe
//   match_o              key_a_o == key_b_o, valid from done_o onward
//   err_o                watchdog abort, sticky until next start
module dh_exchange_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] a_priv_i,
    input  logic [WIDTH-1:0] b_priv_i,
    output logic             me_start_o,
    output logic [WIDTH-1:0] me_base_o,
    output logic [WIDTH-1:0] me_exp_o,
    output logic [WIDTH-1:0] me_mod_o,
    input  logic             me_done_i,
    input  logic [WIDTH-1:0] me_result_i,
    output logic [WIDTH-1:0] pub_a_o,
    output logic [WIDTH-1:0] pub_b_o,
    output logic [WIDTH-1:0] key_a_o,
    output logic [WIDTH-1:0] key_b_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             match_o,
    output logic             err_o
);

    typedef enum logic [2:0] {
        IDLE, PUB_A, PUB_B, SEC_A, SEC_B, CMP, FIN, ERR
    } state_t;

    state_t           state, state_nx;
    logic             issue, issue_nx;   // 1 = ISSUE phase, 0 = WAIT phase
    logic [TW-1:0]    wdog, wdog_nx;
    logic             accept, capture, set_err;

    logic [WIDTH-1:0] g_q, p_q, a_q, b_q;
    logic [WIDTH-1:0] pub_a_q, pub_b_q, key_a_q, key_b_q;
    logic             match_q, err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            issue   <= 1'b0;
            wdog    <= '0;
            g_q     <= '0;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            pub_a_q <= '0;
            pub_b_q <= '0;
            key_a_q <= '0;
            key_b_q <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            issue <= issue_nx;
            wdog  <= wdog_nx;
            if (accept) begin
                g_q     <= g_i;
                p_q     <= p_i;
                a_q     <= a_priv_i;
                b_q     <= b_priv_i;
                pub_a_q <= '0;
                pub_b_q <= '0;
                key_a_q <= '0;
                key_b_q <= '0;
                match_q <= 1'b0;
                err_q   <= 1'b0;
            end
            if (capture) begin
                case (state)
                    PUB_A:   pub_a_q <= me_result_i;
                    PUB_B:   pub_b_q <= me_result_i;
                    SEC_A:   key_a_q <= me_result_i;
                    SEC_B:   key_b_q <= me_result_i;
                    default: ;
                endcase
            end
            if (state == CMP) match_q <= (key_a_q == key_b_q);
            if (set_err)      err_q   <= 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        issue_nx   = issue;
        wdog_nx    = wdog;
        accept     = 1'b0;
        capture    = 1'b0;
        set_err    = 1'b0;
        me_start_o = 1'b0;
        me_base_o  = '0;
        me_exp_o   = '0;
        me_mod_o   = '0;

        case (state)
            PUB_A: begin me_base_o = g_q;     me_exp_o = a_q; me_mod_o = p_q; end
            PUB_B: begin me_base_o = g_q;     me_exp_o = b_q; me_mod_o = p_q; end
            SEC_A: begin me_base_o = pub_b_q; me_exp_o = a_q; me_mod_o = p_q; end
            SEC_B: begin me_base_o = pub_a_q; me_exp_o = b_q; me_mod_o = p_q; end
            default: ;
        endcase

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nx = PUB_A;
                    issue_nx = 1'b1;
                    accept   = 1'b1;
                end
            end
            PUB_A, PUB_B, SEC_A, SEC_B: begin
                if (issue) begin
                    me_start_o = 1'b1;
                    issue_nx   = 1'b0;
                    wdog_nx    = '0;
                end else if (me_done_i) begin
                    // done is checked before the timeout so a coincident result still counts
                    capture  = 1'b1;
                    issue_nx = 1'b1;
                    case (state)
                        PUB_A:   state_nx = PUB_B;
                        PUB_B:   state_nx = SEC_A;
                        SEC_A:   state_nx = SEC_B;
                        default: state_nx = CMP;
                    endcase
                end else if (wdog == TW'(TIMEOUT - 1)) begin
                    state_nx = ERR;
                    issue_nx = 1'b0;
                    set_err  = 1'b1;
                end else begin
                    wdog_nx = wdog + TW'(1);
                end
            end
            CMP:     state_nx = FIN;
            FIN:     state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign pub_a_o = pub_a_q;
    assign pub_b_o = pub_b_q;
    assign key_a_o = key_a_q;
    assign key_b_o = key_b_q;
    assign match_o = match_q;
    assign err_o   = err_q;
    assign busy_o  = (state != IDLE);
    assign done_o  = (state == FIN) || (state == ERR);

endmodule
